// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// bnn_pkg : shared FSM state encoding and width helper for the BNN classifier
// Rev 1.0
// ============================================================================
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold any count in 0..n inclusive
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_seq_classifier_if.sv
`default_nettype none
// ============================================================================
// bnn_seq_classifier_if : feature/result handshakes and weight write port
// Rev 1.0
// ============================================================================
interface bnn_seq_classifier_if #(
    parameter int IN_W        = 7,
    parameter int NUM_CLASSES = 10
);
    import bnn_pkg::*;

    localparam int CLS_W   = $clog2(NUM_CLASSES);
    localparam int OUT_W   = cnt_w(NUM_CLASSES);
    localparam int SCORE_W = cnt_w(IN_W);

    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic               wr_en;
    logic [CLS_W-1:0]   wr_addr;
    logic [IN_W-1:0]    wr_data;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_class;
    logic [SCORE_W-1:0] out_score;
    logic               out_match;

    modport master (
        output in_valid, in_data, wr_en, wr_addr, wr_data, out_ready,
        input  in_ready, out_valid, out_class, out_score, out_match
    );

    modport slave (
        input  in_valid, in_data, wr_en, wr_addr, wr_data, out_ready,
        output in_ready, out_valid, out_class, out_score, out_match
    );

endinterface
`default_nettype wire

// File: rtl/bnn_popcount.sv
`default_nettype none
// ============================================================================
// bnn_popcount : combinational XNOR-popcount of a feature against a weight
// Rev 1.0
// ============================================================================
module bnn_popcount
    import bnn_pkg::*;
#(
    parameter int IN_W = 7
) (
    input  logic [IN_W-1:0]          x,
    input  logic [IN_W-1:0]          w,
    output logic [cnt_w(IN_W)-1:0]   score
);

    localparam int SCORE_W = cnt_w(IN_W);

    logic [IN_W-1:0] w_agree;

    assign w_agree = ~(x ^ w);

    always_comb begin
        score = '0;
        for (int i = 0; i < IN_W; i++) begin
            score = score + SCORE_W'(w_agree[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/bnn_seq_classifier.sv
`default_nettype none
// ============================================================================
// bnn_seq_classifier : scans one stored weight vector per cycle, reports best
// Rev 1.0
// ============================================================================
module bnn_seq_classifier
    import bnn_pkg::*;
#(
    parameter int                            IN_W         = 7,
    parameter int                            NUM_CLASSES  = 10,
    parameter int                            MATCH_THRESH = IN_W,
    parameter logic [NUM_CLASSES*IN_W-1:0]   WEIGHT_INIT  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bnn_seq_classifier_if.slave   bus
);

    localparam int                 CLS_W    = $clog2(NUM_CLASSES);
    localparam int                 OUT_W    = cnt_w(NUM_CLASSES);
    localparam int                 SCORE_W  = cnt_w(IN_W);
    localparam logic [CLS_W-1:0]   LAST_IDX = CLS_W'(NUM_CLASSES - 1);
    localparam logic [SCORE_W-1:0] THRESH   = SCORE_W'(MATCH_THRESH);

    state_t             r_state;
    state_t             w_state_next;
    logic [IN_W-1:0]    r_weights [NUM_CLASSES];
    logic [IN_W-1:0]    r_x;
    logic [CLS_W-1:0]   r_idx;
    logic [CLS_W-1:0]   r_best_idx;
    logic [SCORE_W-1:0] r_best_score;
    logic [OUT_W-1:0]   r_out_class;
    logic [SCORE_W-1:0] r_out_score;
    logic               r_out_match;

    logic [SCORE_W-1:0] w_score;
    logic [SCORE_W-1:0] w_best_score;
    logic [CLS_W-1:0]   w_best_idx;
    logic               w_accept;
    logic               w_last;
    logic               w_take;
    logic               w_match;
    logic               w_wr_ok;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_wr_ok  = (r_state == IDLE) && bus.wr_en && (int'(bus.wr_addr) < NUM_CLASSES);

    bnn_popcount #(
        .IN_W (IN_W)
    ) u_popcount (
        .x     (r_x),
        .w     (r_weights[r_idx]),
        .score (w_score)
    );

    // Strict greater-than keeps the lowest index on ties
    assign w_take       = (r_idx == '0) || (w_score > r_best_score);
    assign w_best_score = w_take ? w_score : r_best_score;
    assign w_best_idx   = w_take ? r_idx   : r_best_idx;
    assign w_match      = (w_best_score >= THRESH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = SCAN;
            SCAN:    if (w_last)        w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x          <= '0;
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_out_class  <= '0;
            r_out_score  <= '0;
            r_out_match  <= 1'b0;
        end else if (w_accept) begin
            r_x          <= bus.in_data;
            r_idx        <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
        end else if (r_state == SCAN) begin
            r_best_idx   <= w_best_idx;
            r_best_score <= w_best_score;
            if (w_last) begin
                r_idx       <= '0;
                r_out_class <= w_match ? OUT_W'(w_best_idx) : '1;
                r_out_score <= w_best_score;
                r_out_match <= w_match;
            end else begin
                r_idx <= r_idx + CLS_W'(1);
            end
        end
    end

    // A write coinciding with an accept lands before the first scan cycle reads it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_weights[k] <= WEIGHT_INIT[k*IN_W +: IN_W];
            end
        end else if (w_wr_ok) begin
            r_weights[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_class = r_out_class;
    assign bus.out_score = r_out_score;
    assign bus.out_match = r_out_match;

endmodule
`default_nettype wire
